// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcodes, load/store width codes, responder FSM states
// and the access-fault rule used by the data-memory responder.
package rv_pkg;

    typedef enum logic [6:0] {
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        BRANCH = 7'b1100011,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        SYSTEM = 7'b1110011
    } opcode_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_WAIT = 3'b010,
        ST_RESP = 3'b100
    } dmem_state_t;

    // Stores only know B/H/W; unsigned codes are meaningless for a write.
    function automatic logic access_fault(
        input logic       write,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo,
        input logic       out_of_range
    );
        logic illegal;
        logic misalign;
        illegal  = (funct3 == 3'b011) || (funct3[2] && funct3[1]) || (write && funct3[2]);
        misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return illegal || misalign || out_of_range;
    endfunction

endpackage

// File: rtl/dmem_extract.sv
// Big-endian byte-lane select and sign/zero extension of a RAM word for loads.
module dmem_extract
    import rv_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    output logic [31:0] rdata
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = word[31:24];
            2'd1:    lane_b = word[23:16];
            2'd2:    lane_b = word[15:8];
            default: lane_b = word[7:0];
        endcase
        lane_h = addr_lo[1] ? word[15:0] : word[31:16];

        case (funct3)
            F3_B:    rdata = {{24{lane_b[7]}}, lane_b};
            F3_H:    rdata = {{16{lane_h[15]}}, lane_h};
            F3_W:    rdata = word;
            F3_BU:   rdata = {24'b0, lane_b};
            F3_HU:   rdata = {16'b0, lane_h};
            default: rdata = 32'b0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory bus target: big-endian byte RAM plus one GPIO byte, with a
// programmable number of wait states between request acceptance and response.
//
// state   | meaning
// ST_IDLE | req_ready high, next request is accepted
// ST_WAIT | wait counter running; access commits on its terminal count
// ST_RESP | one-cycle resp_valid with registered rdata/err
module dmem_responder
    import rv_pkg::*;
#(
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] GPIO_ADDR   = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [7:0]  gpio
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    dmem_state_t state, state_nxt;
    logic [3:0]  wait_cnt;
    logic        accept, commit;

    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata;

    logic        a_write;
    logic [2:0]  a_funct3;
    logic [31:0] a_addr, a_wdata;

    logic          is_gpio, out_of_range, fault;
    logic [AW-1:0] idx, wbase, hbase;
    logic [31:0]   ram_word, ext_rdata;
    logic [7:0]    mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        commit     = 1'b0;
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        commit    = 1'b1;
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    commit    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // In IDLE the live request is the operand, so a zero-wait access commits on its accept edge.
    assign a_write  = (state == ST_IDLE) ? req_write  : r_write;
    assign a_funct3 = (state == ST_IDLE) ? req_funct3 : r_funct3;
    assign a_addr   = (state == ST_IDLE) ? req_addr   : r_addr;
    assign a_wdata  = (state == ST_IDLE) ? req_wdata  : r_wdata;

    assign is_gpio      = (a_addr == GPIO_ADDR);
    assign out_of_range = !is_gpio && (a_addr >= DEPTH_W);
    assign fault        = access_fault(a_write, a_funct3, a_addr[1:0], out_of_range);

    assign idx   = a_addr[AW-1:0];
    assign wbase = idx & ~AW'(3);
    assign hbase = idx & ~AW'(1);
    assign ram_word = {mem[wbase], mem[wbase | AW'(1)], mem[wbase | AW'(2)], mem[wbase | AW'(3)]};

    dmem_extract u_extract (
        .addr_lo (a_addr[1:0]),
        .funct3  (a_funct3),
        .word    (ram_word),
        .rdata   (ext_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= 4'd0;
            r_write    <= 1'b0;
            r_funct3   <= 3'b0;
            r_addr     <= 32'b0;
            r_wdata    <= 32'b0;
            resp_rdata <= 32'b0;
            resp_err   <= 1'b0;
            gpio       <= 8'b0;
        end else begin
            if (accept) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                wait_cnt <= WS_LOAD;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (commit) begin
                resp_err <= fault;
                if (fault || a_write) resp_rdata <= 32'b0;
                else if (is_gpio)     resp_rdata <= {24'b0, gpio};
                else                  resp_rdata <= ext_rdata;
                if (!fault && a_write && is_gpio) gpio <= a_wdata[7:0];
            end else if (state == ST_RESP) begin
                resp_rdata <= 32'b0;
                resp_err   <= 1'b0;
            end
        end
    end

    // RAM has no reset; a reset edge only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!rst && commit && !fault && a_write && !is_gpio) begin
            case (a_funct3[1:0])
                2'b00: mem[idx] <= a_wdata[7:0];
                2'b01: begin
                    mem[hbase]          <= a_wdata[15:8];
                    mem[hbase | AW'(1)] <= a_wdata[7:0];
                end
                2'b10: begin
                    mem[wbase]          <= a_wdata[31:24];
                    mem[wbase | AW'(1)] <= a_wdata[23:16];
                    mem[wbase | AW'(2)] <= a_wdata[15:8];
                    mem[wbase | AW'(3)] <= a_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with three wait states.
module tb_dmem_responder;
    import rv_pkg::*;

    localparam int          DEPTH = 4096;
    localparam int          WS    = 3;
    localparam logic [31:0] GA    = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [7:0]  gpio;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS), .GPIO_ADDR(GA)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .gpio       (gpio)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rd;
    logic        er;
    logic [7:0]  gp;
    int          lat;

    typedef struct packed {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        logic [7:0]  gp;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] exp_rd,
                                input logic exp_err, input logic [7:0] exp_gp);
        vec_t v;
        v.w = w; v.f3 = f3; v.a = a; v.wd = wd; v.rd = exp_rd; v.err = exp_err; v.gp = exp_gp;
        return v;
    endfunction

    // One request, then wait (bounded) for its response; lat counts sampled cycles after acceptance.
    task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; rd = 32'hBAD0_BAD0; er = 1'b1; gp = 8'h5A;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                rd = resp_rdata; er = resp_err; gp = gpio; lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset resp_rdata: got %h want 0", resp_rdata); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset resp_err: got %b want 0", resp_err); end
        n_cmp++; if (gpio !== 8'h00) begin n_bad++; $display("FAIL reset gpio: got %h want 00", gpio); end
        rst = 1'b0;
    endtask

    task automatic test_word();
        vec_t t[$];
        t.push_back(mk(1, F3_W,  0, 32'h0001_F000, 32'h0, 0, 0));
        t.push_back(mk(0, F3_W,  0, 0, 32'h0001_F000, 0, 0));
        t.push_back(mk(0, F3_BU, 0, 0, 32'h0000_0000, 0, 0));
        t.push_back(mk(0, F3_BU, 1, 0, 32'h0000_0001, 0, 0));
        t.push_back(mk(0, F3_B,  2, 0, 32'hFFFF_FFF0, 0, 0));
        t.push_back(mk(0, F3_BU, 2, 0, 32'h0000_00F0, 0, 0));
        t.push_back(mk(0, F3_B,  3, 0, 32'h0000_0000, 0, 0));
        t.push_back(mk(0, F3_H,  0, 0, 32'h0000_0001, 0, 0));
        t.push_back(mk(0, F3_HU, 2, 0, 32'h0000_F000, 0, 0));
        t.push_back(mk(0, F3_H,  2, 0, 32'hFFFF_F000, 0, 0));
        for (int i = 0; i < t.size(); i++) begin
            access(t[i].w, t[i].f3, t[i].a, t[i].wd);
            n_cmp++; if (lat != WS + 1) begin n_bad++; $display("FAIL word[%0d] latency: got %0d want %0d", i, lat, WS + 1); end
            n_cmp++; if (rd !== t[i].rd) begin n_bad++; $display("FAIL word[%0d] rdata: got %h want %h", i, rd, t[i].rd); end
            n_cmp++; if (er !== t[i].err) begin n_bad++; $display("FAIL word[%0d] err: got %b want %b", i, er, t[i].err); end
        end
        @(negedge clk);
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rdata_after_resp: got %h want 0", resp_rdata); end
    endtask

    task automatic test_bytes();
        vec_t t[$];
        t.push_back(mk(1, F3_W,  4, 32'h0, 32'h0, 0, 0));
        t.push_back(mk(1, F3_B,  5, 32'h1234_5680, 32'h0, 0, 0));
        t.push_back(mk(0, F3_B,  5, 0, 32'hFFFF_FF80, 0, 0));
        t.push_back(mk(0, F3_BU, 5, 0, 32'h0000_0080, 0, 0));
        t.push_back(mk(0, F3_W,  4, 0, 32'h0080_0000, 0, 0));
        t.push_back(mk(1, F3_H,  6, 32'hABCD_1234, 32'h0, 0, 0));
        t.push_back(mk(0, F3_W,  4, 0, 32'h0080_1234, 0, 0));
        t.push_back(mk(0, F3_HU, 6, 0, 32'h0000_1234, 0, 0));
        t.push_back(mk(1, F3_B,  7, 32'h0000_00FE, 32'h0, 0, 0));
        t.push_back(mk(1, F3_H,  4, 32'h0000_8001, 32'h0, 0, 0));
        t.push_back(mk(0, F3_H,  4, 0, 32'hFFFF_8001, 0, 0));
        t.push_back(mk(0, F3_W,  4, 0, 32'h8001_12FE, 0, 0));
        for (int i = 0; i < t.size(); i++) begin
            access(t[i].w, t[i].f3, t[i].a, t[i].wd);
            n_cmp++; if (lat != WS + 1) begin n_bad++; $display("FAIL bytes[%0d] latency: got %0d want %0d", i, lat, WS + 1); end
            n_cmp++; if (rd !== t[i].rd) begin n_bad++; $display("FAIL bytes[%0d] rdata: got %h want %h", i, rd, t[i].rd); end
            n_cmp++; if (er !== t[i].err) begin n_bad++; $display("FAIL bytes[%0d] err: got %b want %b", i, er, t[i].err); end
        end
    endtask

    task automatic test_faults();
        vec_t t[$];
        t.push_back(mk(1, F3_W,   0, 32'h1122_3344, 32'h0, 0, 0));
        t.push_back(mk(1, F3_H,   1, 32'h0000_FFFF, 32'h0, 1, 0));
        t.push_back(mk(0, F3_W,   0, 0, 32'h1122_3344, 0, 0));
        t.push_back(mk(0, F3_W,   6, 0, 32'h0, 1, 0));
        t.push_back(mk(0, F3_W,   DEPTH, 0, 32'h0, 1, 0));
        t.push_back(mk(1, F3_W,   DEPTH - 4, 32'hA5A5_5A5A, 32'h0, 0, 0));
        t.push_back(mk(0, F3_W,   DEPTH - 4, 0, 32'hA5A5_5A5A, 0, 0));
        t.push_back(mk(0, F3_W,   DEPTH - 2, 0, 32'h0, 1, 0));
        t.push_back(mk(0, F3_H,   DEPTH - 2, 0, 32'h0000_5A5A, 0, 0));
        t.push_back(mk(0, F3_HU,  DEPTH - 3, 0, 32'h0, 1, 0));
        t.push_back(mk(0, F3_B,   DEPTH - 1, 0, 32'h0000_005A, 0, 0));
        t.push_back(mk(0, 3'b011, 0, 0, 32'h0, 1, 0));
        t.push_back(mk(0, 3'b110, 0, 0, 32'h0, 1, 0));
        t.push_back(mk(0, 3'b111, 0, 0, 32'h0, 1, 0));
        t.push_back(mk(1, F3_BU,  0, 32'h0000_00FF, 32'h0, 1, 0));
        t.push_back(mk(1, F3_HU,  2, 32'h0000_FFFF, 32'h0, 1, 0));
        t.push_back(mk(1, F3_W,   DEPTH, 32'h0000_0001, 32'h0, 1, 0));
        t.push_back(mk(0, F3_W,   0, 0, 32'h1122_3344, 0, 0));
        t.push_back(mk(0, F3_W,   32'hFFFF_FF04, 0, 32'h0, 1, 0));
        t.push_back(mk(0, F3_B,   32'h8000_0000, 0, 32'h0, 1, 0));
        for (int i = 0; i < t.size(); i++) begin
            access(t[i].w, t[i].f3, t[i].a, t[i].wd);
            n_cmp++; if (lat != WS + 1) begin n_bad++; $display("FAIL fault[%0d] latency: got %0d want %0d", i, lat, WS + 1); end
            n_cmp++; if (rd !== t[i].rd) begin n_bad++; $display("FAIL fault[%0d] rdata: got %h want %h", i, rd, t[i].rd); end
            n_cmp++; if (er !== t[i].err) begin n_bad++; $display("FAIL fault[%0d] err: got %b want %b", i, er, t[i].err); end
        end
    endtask

    task automatic test_gpio();
        vec_t t[$];
        t.push_back(mk(1, F3_B,  GA, 32'h0000_00A5, 32'h0, 0, 8'hA5));
        t.push_back(mk(0, F3_BU, GA, 0, 32'h0000_00A5, 0, 8'hA5));
        t.push_back(mk(0, F3_B,  GA, 0, 32'h0000_00A5, 0, 8'hA5));
        t.push_back(mk(0, F3_W,  GA, 0, 32'h0000_00A5, 0, 8'hA5));
        t.push_back(mk(1, F3_W,  GA, 32'h1234_5677, 32'h0, 0, 8'h77));
        t.push_back(mk(1, F3_H,  GA, 32'h0000_BEEF, 32'h0, 0, 8'hEF));
        t.push_back(mk(1, F3_BU, GA, 32'h0000_0011, 32'h0, 1, 8'hEF));
        t.push_back(mk(1, F3_B,  GA + 1, 32'h0000_0022, 32'h0, 1, 8'hEF));
        t.push_back(mk(0, F3_HU, GA, 0, 32'h0000_00EF, 0, 8'hEF));
        for (int i = 0; i < t.size(); i++) begin
            access(t[i].w, t[i].f3, t[i].a, t[i].wd);
            n_cmp++; if (rd !== t[i].rd) begin n_bad++; $display("FAIL gpio[%0d] rdata: got %h want %h", i, rd, t[i].rd); end
            n_cmp++; if (er !== t[i].err) begin n_bad++; $display("FAIL gpio[%0d] err: got %b want %b", i, er, t[i].err); end
            n_cmp++; if (gp !== t[i].gp) begin n_bad++; $display("FAIL gpio[%0d] gpio_in_resp: got %h want %h", i, gp, t[i].gp); end
        end
    endtask

    task automatic test_timing();
        logic extra;
        access(1'b1, F3_W, 32'h40, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h40; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_write = 1'b1; req_wdata = 32'hCAFE_BABE;
        for (int c = 1; c <= WS + 1; c++) begin
            @(negedge clk);
            n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL timing req_ready cycle %0d: got %b want 0", c, req_ready); end
            n_cmp++; if (resp_valid !== (c == WS + 1)) begin n_bad++; $display("FAIL timing resp_valid cycle %0d: got %b want %b", c, resp_valid, c == WS + 1); end
        end
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL timing ready_after_resp: got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL timing single_pulse: got %b want 0", resp_valid); end
        extra = 1'b0;
        repeat (8) begin @(negedge clk); if (resp_valid) extra = 1'b1; end
        n_cmp++; if (extra !== 1'b0) begin n_bad++; $display("FAIL timing ignored_req_responded: got %b want 0", extra); end
        access(1'b0, F3_W, 32'h40, 32'h0);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL timing ignored_store_written: got %h want 0", rd); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h0; req_wdata = 32'h0;
        @(posedge clk);
        for (int c = 1; c <= 2 * (WS + 2); c++) begin
            @(negedge clk);
            n_cmp++;
            if (resp_valid !== ((c == WS + 1) || (c == 2 * WS + 3))) begin
                n_bad++; $display("FAIL b2b resp_valid cycle %0d: got %b want %b", c, resp_valid, (c == WS + 1) || (c == 2 * WS + 3));
            end
            if (c == 2 * WS + 3) begin
                n_cmp++; if (resp_rdata !== 32'h1122_3344) begin n_bad++; $display("FAIL b2b rdata: got %h want 11223344", resp_rdata); end
            end
        end
        req_valid = 1'b0;
        repeat (WS + 3) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic seen;
        access(1'b1, F3_W, 32'h8, 32'h2222_2222);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h8; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL abort req_ready: got %b want 1", req_ready); end
        n_cmp++; if (gpio !== 8'h00) begin n_bad++; $display("FAIL abort gpio: got %h want 00", gpio); end
        seen = resp_valid;
        repeat (8) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort resp_valid_seen: got %b want 0", seen); end
        access(1'b0, F3_W, 32'h8, 32'h0);
        n_cmp++; if (rd !== 32'h2222_2222) begin n_bad++; $display("FAIL abort mem8: got %h want 22222222", rd); end
    endtask

    task automatic test_reset_with_req();
        logic seen;
        access(1'b1, F3_W, 32'hC, 32'h0000_0033);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'hC; req_wdata = 32'h0000_0099;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_req resp_valid_seen: got %b want 0", seen); end
        access(1'b0, F3_W, 32'hC, 32'h0);
        n_cmp++; if (rd !== 32'h0000_0033) begin n_bad++; $display("FAIL rst_req mem12: got %h want 00000033", rd); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_word();
        test_timing();
        test_bytes();
        test_faults();
        test_back_to_back();
        test_gpio();
        test_reset_abort();
        test_reset_with_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
